// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package ifq_pkg;

    localparam int IFQ_ADDR_W = 32;
    localparam int IFQ_DATA_W = 32;

    typedef struct packed {
        logic [IFQ_ADDR_W-1:0] pc;
        logic [IFQ_DATA_W-1:0] instr;
    } ifq_entry_t;

    localparam ifq_entry_t IFQ_NOP = '0;

    function automatic int ifq_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Instruction memory req/gnt/rvalid bus between fetch and memory.
interface ifq_imem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ifq_ring.sv
// DEPTH-entry circular buffer with push, pop, synchronous flush and head read.
module ifq_ring
    import ifq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = ifq_ptr_w(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  ifq_entry_t wdata,
    output ifq_entry_t head,
    output logic [PW:0] count
);

    ifq_entry_t      mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case (1'b1)
                push && !pop: count <= count + (PW+1)'(1);
                pop && !push: count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wdata;
    end

    assign head = (count == '0) ? IFQ_NOP : mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Prefetching instruction fetch front end with flush/redirect on branch.
// Define IFQ_STATS_EN to add flush/stall/empty event counters.
module if_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              Branch_taken,
    input  logic [ADDR_W-1:0] BranchAddr,
    ifq_imem_if.master        imem,
    output logic              valid,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] Instruction
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]       stat_flush_cnt,
    output logic [31:0]       stat_stall_cnt,
    output logic [31:0]       stat_empty_cnt
`endif
);

    localparam int          PW   = ifq_ptr_w(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              outstanding;
    logic              discard;
    logic [PW:0]       count;
    logic              grant;
    logic              rsp;
    logic              push;
    logic              pop;
    ifq_entry_t        wr_entry;
    ifq_entry_t        head;

    assign imem.req  = !rst && !outstanding && (count != FULL)
                       && !Branch_taken;
    assign imem.addr = fetch_pc;

    assign grant = imem.req && imem.gnt;
    assign rsp   = imem.rvalid && outstanding;
    assign push  = rsp && !discard && !Branch_taken;
    assign pop   = valid && !freeze && !Branch_taken;

    always_comb begin
        wr_entry       = IFQ_NOP;
        wr_entry.pc    = IFQ_ADDR_W'(inflight_pc + ADDR_W'(4));
        wr_entry.instr = IFQ_DATA_W'(imem.rdata);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (Branch_taken) begin
            // A response still owed after this edge belongs to the old path.
            fetch_pc    <= BranchAddr;
            outstanding <= outstanding && !imem.rvalid;
            discard     <= outstanding && !imem.rvalid;
        end else if (grant) begin
            outstanding <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + ADDR_W'(4);
        end else if (rsp) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end
    end

    ifq_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .flush (Branch_taken),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .head  (head),
        .count (count)
    );

    assign valid       = (count != '0);
    assign PC          = ADDR_W'(head.pc);
    assign Instruction = DATA_W'(head.instr);

`ifdef IFQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_flush_cnt <= '0;
            stat_stall_cnt <= '0;
            stat_empty_cnt <= '0;
        end else begin
            if (Branch_taken)
                stat_flush_cnt <= stat_flush_cnt + 32'd1;
            if (valid && freeze)
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            if (!valid)
                stat_empty_cnt <= stat_empty_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed cycle-table bench for if_prefetch_queue with a latency-programmable memory model.
module tb_if_prefetch_queue;

    typedef struct {
        logic        rst;
        logic        fr;
        logic        br;
        logic [31:0] ba;
        logic        gnt;
        int          lat;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef IFQ_STATS_EN
    logic [31:0] st_flush;
    logic [31:0] st_stall;
    logic [31:0] st_empty;
    logic [31:0] e0;
`endif

    ifq_imem_if #(.ADDR_W(32), .DATA_W(32)) imem();

    if_prefetch_queue #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_taken (br_taken),
        .BranchAddr   (br_addr),
        .imem         (imem),
        .valid        (valid),
        .PC           (pc),
        .Instruction  (instr)
`ifdef IFQ_STATS_EN
        ,
        .stat_flush_cnt (st_flush),
        .stat_stall_cnt (st_stall),
        .stat_empty_cnt (st_empty)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    vec_t        vq[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1300_0013;
    endfunction

    function automatic vec_t mk(input logic r, f, b, input logic [31:0] ba,
                                input logic g, input int l,
                                input logic q, input logic [31:0] ad,
                                input logic v, input logic [31:0] p);
        vec_t t;
        t.rst = r; t.fr = f; t.br = b; t.ba = ba; t.gnt = g; t.lat = l;
        t.req = q; t.addr = ad; t.vld = v; t.pc = p;
        return t;
    endfunction

    task automatic add(input logic r, f, b, input logic [31:0] ba,
                       input logic g, input int l,
                       input logic q, input logic [31:0] ad,
                       input logic v, input logic [31:0] p);
        vq.push_back(mk(r, f, b, ba, g, l, q, ad, v, p));
    endtask

    task automatic rstrows();
        add(1, 0, 0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
        add(1, 0, 0, 0, 1, 1, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic chk(input string nm, input int row,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, got, exp);
        end
    endtask

    task automatic step(input vec_t r, input int row);
        logic [31:0] ei;
        @(posedge clk);
        #1;
        rst         = r.rst;
        freeze      = r.fr;
        br_taken    = r.br;
        br_addr     = r.ba;
        imem.gnt    = r.gnt;
        imem.rvalid = 1'b0;
        if (r.rst) begin
            mem_cnt = 0;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem.rvalid = 1'b1;
                imem.rdata  = instr_of(mem_addr);
            end
        end
        @(negedge clk);
        ei = r.vld ? instr_of(r.pc - 32'd4) : 32'h0;
        chk("req",   row, {31'h0, imem.req}, {31'h0, r.req});
        chk("addr",  row, imem.addr, r.addr);
        chk("valid", row, {31'h0, valid}, {31'h0, r.vld});
        chk("pc",    row, pc, r.pc);
        chk("instr", row, instr, ei);
        if (imem.req && imem.gnt) begin
            mem_cnt  = r.lat;
            mem_addr = imem.addr;
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        freeze      = 1'b0;
        br_taken    = 1'b0;
        br_addr     = '0;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;

        // streaming, one entry per two cycles
        rstrows();
        add(0, 0, 0, 0, 1, 1, 1, 32'h0, 0, 32'h0);
        add(0, 0, 0, 0, 1, 1, 0, 32'h4, 0, 32'h0);
        add(0, 0, 0, 0, 1, 1, 1, 32'h4, 1, 32'h4);
        add(0, 0, 0, 0, 1, 1, 0, 32'h8, 0, 32'h0);
        add(0, 0, 0, 0, 1, 1, 1, 32'h8, 1, 32'h8);
        add(0, 0, 0, 0, 1, 1, 0, 32'hC, 0, 32'h0);
        add(0, 0, 0, 0, 1, 1, 1, 32'hC, 1, 32'hC);

        // fill under freeze, then drain and resume
        rstrows();
        add(0, 1, 0, 0, 1, 1, 1, 32'h0,  0, 32'h0);
        add(0, 1, 0, 0, 1, 1, 0, 32'h4,  0, 32'h0);
        add(0, 1, 0, 0, 1, 1, 1, 32'h4,  1, 32'h4);
        add(0, 1, 0, 0, 1, 1, 0, 32'h8,  1, 32'h4);
        add(0, 1, 0, 0, 1, 1, 1, 32'h8,  1, 32'h4);
        add(0, 1, 0, 0, 1, 1, 0, 32'hC,  1, 32'h4);
        add(0, 1, 0, 0, 1, 1, 1, 32'hC,  1, 32'h4);
        add(0, 1, 0, 0, 1, 1, 0, 32'h10, 1, 32'h4);
        add(0, 1, 0, 0, 1, 1, 0, 32'h10, 1, 32'h4);
        add(0, 1, 0, 0, 1, 1, 0, 32'h10, 1, 32'h4);
        add(0, 0, 0, 0, 1, 1, 0, 32'h10, 1, 32'h4);
        add(0, 0, 0, 0, 1, 1, 1, 32'h10, 1, 32'h8);
        add(0, 0, 0, 0, 1, 1, 0, 32'h14, 1, 32'hC);
        add(0, 0, 0, 0, 1, 1, 1, 32'h14, 1, 32'h10);
        add(0, 0, 0, 0, 1, 1, 0, 32'h18, 1, 32'h14);
        add(0, 0, 0, 0, 1, 1, 1, 32'h18, 1, 32'h18);
        add(0, 0, 0, 0, 1, 1, 0, 32'h1C, 0, 32'h0);
        add(0, 0, 0, 0, 1, 1, 1, 32'h1C, 1, 32'h1C);

        // branch while a slow response is outstanding
        rstrows();
        add(0, 0, 0, 0,        1, 3, 1, 32'h0,   0, 32'h0);
        add(0, 0, 1, 32'h100,  1, 3, 0, 32'h4,   0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 0, 32'h100, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 0, 32'h100, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 1, 32'h100, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 0, 32'h104, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 0, 32'h104, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 0, 32'h104, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 1, 32'h104, 1, 32'h104);

        // back-to-back branches with stale response pending
        rstrows();
        add(0, 0, 0, 0,        1, 3, 1, 32'h0,   0, 32'h0);
        add(0, 0, 1, 32'h100,  1, 3, 0, 32'h4,   0, 32'h0);
        add(0, 0, 1, 32'h300,  1, 3, 0, 32'h100, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 0, 32'h300, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 1, 32'h300, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 0, 32'h304, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 0, 32'h304, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 0, 32'h304, 0, 32'h0);
        add(0, 0, 0, 0,        1, 3, 1, 32'h304, 1, 32'h304);

        // branch coincides with the rvalid of the last free slot
        rstrows();
        add(0, 1, 0, 0,        1, 1, 1, 32'h0,   0, 32'h0);
        add(0, 1, 0, 0,        1, 1, 0, 32'h4,   0, 32'h0);
        add(0, 1, 0, 0,        1, 1, 1, 32'h4,   1, 32'h4);
        add(0, 1, 0, 0,        1, 1, 0, 32'h8,   1, 32'h4);
        add(0, 1, 0, 0,        1, 1, 1, 32'h8,   1, 32'h4);
        add(0, 1, 0, 0,        1, 1, 0, 32'hC,   1, 32'h4);
        add(0, 1, 0, 0,        1, 1, 1, 32'hC,   1, 32'h4);
        add(0, 1, 1, 32'h200,  1, 1, 0, 32'h10,  1, 32'h4);
        add(0, 0, 0, 0,        1, 1, 1, 32'h200, 0, 32'h0);
        add(0, 0, 0, 0,        1, 1, 0, 32'h204, 0, 32'h0);
        add(0, 0, 0, 0,        1, 1, 1, 32'h204, 1, 32'h204);

        // grant withheld for five cycles
        rstrows();
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h0);
        add(0, 0, 0, 0, 1, 1, 1, 32'h0, 0, 32'h0);
        add(0, 0, 0, 0, 1, 1, 0, 32'h4, 0, 32'h0);
        add(0, 0, 0, 0, 1, 1, 1, 32'h4, 1, 32'h4);

        rstrows();

        for (int i = 0; i < vq.size(); i++)
            step(vq[i], i);

        // async reset while an entry is valid and a request is in flight
        step(mk(0, 0, 0, 0, 1, 1, 1, 32'h0, 0, 32'h0), 1000);
        step(mk(0, 0, 0, 0, 1, 1, 0, 32'h4, 0, 32'h0), 1001);
        step(mk(0, 0, 0, 0, 1, 3, 1, 32'h4, 1, 32'h4), 1002);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req",   1003, {31'h0, imem.req}, 32'h0);
        chk("rst_addr",  1003, imem.addr, 32'h0);
        chk("rst_valid", 1003, {31'h0, valid}, 32'h0);
        chk("rst_pc",    1003, pc, 32'h0);
        chk("rst_instr", 1003, instr, 32'h0);
        step(mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h0), 1004);
`ifdef IFQ_STATS_EN
        e0 = st_empty;
`endif
        step(mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h0), 1005);
        step(mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h0), 1006);
`ifdef IFQ_STATS_EN
        chk("stat_empty", 1006, st_empty, e0 + 32'd2);
`endif
        step(mk(0, 0, 0, 0, 1, 1, 1, 32'h0, 0, 32'h0), 1007);
        step(mk(0, 0, 0, 0, 1, 1, 0, 32'h4, 0, 32'h0), 1008);
        step(mk(0, 0, 0, 0, 1, 1, 1, 32'h4, 1, 32'h4), 1009);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
# if_prefetch_queue

Parametrised instruction-fetch front end that replaces the single-entry fetch stage feeding the IF/ID register. Issues requests to instruction memory over a req/gnt/rvalid handshake and buffers up to DEPTH fetched {PC+4, instruction} pairs in a circular queue. Presents the head entry to the IF/ID register. Honours `freeze` (hazard stall) and `Branch_taken`, which flushes the queue and redirects fetch to `BranchAddr`.

## Interface
Parameters:
- `ADDR_W`, 32: PC / memory address width.
- `DATA_W`, 32: instruction width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `freeze`  in  1: downstream stall; head entry is held.
- `Branch_taken`  in  1: flush and redirect request.
- `BranchAddr`  in  ADDR_W: redirect target.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  ADDR_W: fetch address.
- `imem_gnt`  in  1: request accepted when `imem_req && imem_gnt`.
- `imem_rvalid`  in  1: response valid, any cycle after grant.
- `imem_rdata`  in  DATA_W: response instruction.
- `valid`  out  1: head entry present.
- `PC`  out  ADDR_W: head entry's fetch address + 4.
- `Instruction`  out  DATA_W: head entry instruction.

## Operation
- State: `fetch_pc`, `count` (0..DEPTH), `rd_ptr`/`wr_ptr` (log2 DEPTH, wrap), `outstanding` (0/1), `discard` (0/1), and `inflight_pc`.
- Request: `imem_req = !outstanding && (count < DEPTH) && !Branch_taken`, with `imem_addr = fetch_pc`. At most one request is outstanding. The credit check means the queue never overflows.
- On grant: `outstanding←1`, `inflight_pc←fetch_pc`, `fetch_pc←fetch_pc+4` (modulo 2^ADDR_W).
- On `imem_rvalid`: `outstanding←0`.
  - If `discard` is set, drop the data and clear `discard`.
  - Otherwise write {`inflight_pc+4`, `imem_rdata`} at `wr_ptr`.
- Dequeue: `valid && !freeze` pops the head in that cycle.
- Simultaneous push and pop leave `count` unchanged. Pop is legal with `count==DEPTH`.
- Outputs: `valid = (count!=0)`. `PC`/`Instruction` show the head entry; both are 0 when empty.
- Branch (`Branch_taken=1`) has priority over `freeze`, push and pop. At the edge:
  - `count←0`, both pointers reset to 0, `fetch_pc←BranchAddr`.
  - If a response is still pending after this edge, `discard←1`. This covers `outstanding` with no same-cycle `rvalid`, and a same-cycle grant.
  - A response arriving in the branch cycle is dropped.
- Back-to-back branches: each retargets `fetch_pc`. `discard` stays set until the stale response returns.
- `rvalid` with `outstanding==0` is a protocol error and is ignored.

## Timing
- Reset values:
  - `fetch_pc=RESET_PC`; `count`, `outstanding`, `discard` and pointers 0.
  - `valid=0`, `PC=0`, `Instruction=0`, `imem_req` low during `rst`.
  - Reset mid-request abandons it; the stale `rvalid` is ignored because `outstanding==0`.
- Fetch latency, with grant in cycle N and `rvalid` in N+1: the entry is written at the end of N+1, so `valid=1` in N+2.
- Branch asserted in cycle B: request to `BranchAddr` in B+1 at the earliest (later if the old response is pending). With a 1-cycle response, `valid` rises in B+3.
- Sustained throughput is one instruction per 2 cycles when memory responds in 1 cycle (single outstanding request).
- Outputs are pure functions of registered state; no combinational path from `freeze` to outputs.

## Configuration
- `IFQ_STATS_EN` defined adds three ADDR_W-independent 32-bit outputs. Each wraps on overflow and resets to 0:
  - `stat_flush_cnt`: +1 per `Branch_taken` cycle.
  - `stat_stall_cnt`: +1 per cycle with `valid && freeze`.
  - `stat_empty_cnt`: +1 per cycle with `!valid`.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

## Structure
- Package `ifq_pkg`:
  - `ifq_entry_t` {pc, instr}.
  - `IFQ_NOP` constant (0) used for empty outputs.
  - Helper for pointer width, `$clog2(DEPTH)`.
- Sub-module `ifq_ring`: DEPTH-entry circular buffer with push, pop, synchronous flush, count and head read.
- The top level holds fetch control, outstanding/discard tracking and the optional stats.

## Test plan
- Reset, then `imem_gnt=1` with 1-cycle `rvalid`, `freeze=0` -> first `imem_addr=0x0`; `valid` rises 2 cycles after grant with `PC=0x4`. Subsequent entries carry `PC` 0x8, 0xC, …
- `freeze=1` held, DEPTH=4 -> exactly 4 entries queued, `imem_req` deasserts, head stays `PC=0x4`. Release `freeze` -> entries drain in order, then fetching resumes at 0x10.
- Branch to 0x100 while a response is outstanding (response delayed 3 cycles) -> stale data dropped; next request `imem_addr=0x100`; first valid `PC=0x104`.
- `Branch_taken` and `imem_rvalid` in the same cycle with queue full -> `count=0`, response dropped, `valid=0` the next cycle.
- `imem_gnt=0` for 5 cycles -> `imem_addr` stable and `valid` stays low while empty. With `IFQ_STATS_EN`, `stat_empty_cnt` increments each cycle.
- Assert `rst` mid-stream -> all outputs 0 immediately; after release, fetch restarts at `RESET_PC`; late `rvalid` is ignored.
